// File: rtl/jt10_adpcm_rom_arb_pkg.sv
// jt10_adpcm_rom_arb_pkg: shared FSM states, requester ids and key width
package jt10_adpcm_rom_arb_pkg;
  localparam int KEY_W = 25;
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
endpackage

// File: rtl/jt10_adpcm_rom_port.sv
// jt10_adpcm_rom_port: per-requester new-byte detection, pending key, late flag and data hold
module jt10_adpcm_rom_port
  import jt10_adpcm_rom_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             roe_n,
  input  logic [KEY_W-1:0] key,
  input  logic             grant_take,
  input  logic             deliver,
  input  logic [7:0]       rom_data,
  input  logic             clr_late,
  output logic             pend,
  output logic [KEY_W-1:0] pend_key,
  output logic [7:0]       dout,
  output logic             late
);
  logic [KEY_W-1:0] last_key, flight_key;
  logic valid, busy, det;
  assign det = cen & ~roe_n & (~valid | (key != last_key));
  // pend tracks only the not-yet-issued key; the issued one lives in flight_key until delivery
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend       <= 1'b0;
      pend_key   <= '0;
      flight_key <= '0;
      last_key   <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      dout       <= '0;
      late       <= 1'b0;
    end else begin
      if (det) pend_key <= key;
      pend <= det | (pend & ~grant_take);
      if (grant_take) flight_key <= pend_key;
      busy <= grant_take | (busy & ~deliver);
      if (deliver) begin
        dout     <= rom_data;
        last_key <= flight_key;
        valid    <= 1'b1;
      end
      late <= (det & (pend | busy)) | (late & ~clr_late);
    end
endmodule

// File: rtl/jt10_adpcm_rom_arb.sv
// jt10_adpcm_rom_arb: round-robin sharing of one sample-ROM port between ADPCM-A and ADPCM-B
module jt10_adpcm_rom_arb
  import jt10_adpcm_rom_arb_pkg::*;
#(
  parameter bit LATE_EN = 1'b1
) (
  input  logic             rst_n,
  input  logic             clk,
  input  logic             cen,
  input  logic [19:0]      a_addr,
  input  logic [4:0]       a_bank,
  input  logic             a_roe_n,
  output logic [7:0]       a_dout,
  input  logic [23:0]      b_addr,
  input  logic             b_roe_n,
  output logic [7:0]       b_dout,
  output logic [KEY_W-1:0] rom_addr,
  output logic             rom_sel,
  output logic             rom_req,
  input  logic             rom_ok,
  input  logic [7:0]       rom_data,
  output logic [1:0]       late,
  input  logic [1:0]       clr_late
);
  state_t state;
  logic last_b, pend_a, pend_b, grant_b, take_a, take_b, late_a, late_b;
  logic [KEY_W-1:0] pkey_a, pkey_b;
  // B wins only when A is idle or A was served last
  assign grant_b = pend_b & (~pend_a | ~last_b);
  assign take_a  = (state == IDLE) & pend_a & ~grant_b;
  assign take_b  = (state == IDLE) & grant_b;
  assign late    = LATE_EN ? {late_b, late_a} : 2'b00;
  jt10_adpcm_rom_port u_a (
    .clk(clk), .rst_n(rst_n), .cen(cen), .roe_n(a_roe_n), .key({a_bank, a_addr}),
    .grant_take(take_a), .deliver((state == WAIT) & rom_ok & (rom_sel == REQ_A)),
    .rom_data(rom_data), .clr_late(clr_late[0]),
    .pend(pend_a), .pend_key(pkey_a), .dout(a_dout), .late(late_a)
  );
  jt10_adpcm_rom_port u_b (
    .clk(clk), .rst_n(rst_n), .cen(cen), .roe_n(b_roe_n), .key({1'b0, b_addr}),
    .grant_take(take_b), .deliver((state == WAIT) & rom_ok & (rom_sel == REQ_B)),
    .rom_data(rom_data), .clr_late(clr_late[1]),
    .pend(pend_b), .pend_key(pkey_b), .dout(b_dout), .late(late_b)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      last_b   <= 1'b1;
      rom_addr <= '0;
      rom_sel  <= REQ_A;
      rom_req  <= 1'b0;
    end else
      case (state)
        IDLE: if (pend_a | pend_b) begin
          state    <= REQ;
          rom_sel  <= grant_b ? REQ_B : REQ_A;
          last_b   <= grant_b;
          rom_addr <= grant_b ? pkey_b : pkey_a;
        end
        REQ: begin
          rom_req <= 1'b1;
          state   <= WAIT;
        end
        WAIT: if (rom_ok) begin
          rom_req <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_jt10_adpcm_rom_arb.sv
// tb_jt10_adpcm_rom_arb: scoreboard bench with a transaction-level model of the ROM arbiter
`timescale 1ns/1ps
module tb_jt10_adpcm_rom_arb;
  logic        rst_n, clk, cen, a_roe_n, b_roe_n, rom_sel, rom_req, rom_ok;
  logic [19:0] a_addr;
  logic [4:0]  a_bank;
  logic [23:0] b_addr;
  logic [7:0]  a_dout, b_dout, rom_data;
  logic [24:0] rom_addr;
  logic [1:0]  late, clr_late;

  jt10_adpcm_rom_arb #(.LATE_EN(1'b1)) dut (
    .rst_n(rst_n), .clk(clk), .cen(cen), .a_addr(a_addr), .a_bank(a_bank), .a_roe_n(a_roe_n),
    .a_dout(a_dout), .b_addr(b_addr), .b_roe_n(b_roe_n), .b_dout(b_dout), .rom_addr(rom_addr),
    .rom_sel(rom_sel), .rom_req(rom_req), .rom_ok(rom_ok), .rom_data(rom_data), .late(late),
    .clr_late(clr_late)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [24:0] addr;
    logic [7:0]  data;
  } fetch_t;

  fetch_t q[$];
  int vectors = 0, miscompares = 0, issues = 0;

  logic [24:0] m_last[2];
  logic        m_valid[2];
  logic [7:0]  m_dout[2];
  logic        m_lastg;
  logic [1:0]  m_late;

  function automatic logic [7:0] rb(input logic [24:0] k);
    return k[7:0] ^ k[15:8] ^ k[23:16] ^ {7'b0, k[24]} ^ 8'h7A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: checks every issued fetch and every delivered byte against the scoreboard
  initial begin
    fetch_t cur;
    logic prev_req;
    prev_req = 1'b0;
    cur = '{sel: 1'b0, addr: '0, data: '0};
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev_req = 1'b0;
        continue;
      end
      if (rom_req && !prev_req) begin
        issues++;
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_fetch: got addr %h sel %0d expected no fetch", rom_addr, rom_sel);
        end else begin
          cur = q.pop_front();
          chk("issue_sel", 32'(rom_sel), 32'(cur.sel));
          chk("issue_addr", 32'(rom_addr), 32'(cur.addr));
        end
      end else if (rom_req && prev_req) begin
        chk("addr_stable", {6'b0, rom_sel, rom_addr}, {6'b0, cur.sel, cur.addr});
      end
      if (rom_ok && prev_req)
        chk(cur.sel ? "b_dout_deliver" : "a_dout_deliver", 32'(cur.sel ? b_dout : a_dout), 32'(cur.data));
      prev_req = rom_req;
    end
  end

  initial begin
    #500000;
    miscompares++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1);
  end

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_last[i] = '0;
      m_valid[i] = 1'b0;
      m_dout[i] = '0;
    end
    m_lastg = 1'b1;
    m_late = 2'b00;
  endtask

  task automatic pulse(input bit aa, input logic [24:0] ka, input bit ab, input logic [24:0] kb);
    @(negedge clk);
    cen = 1'b1;
    a_roe_n = !aa;
    {a_bank, a_addr} = ka;
    b_roe_n = !ab;
    b_addr = kb[23:0];
    @(negedge clk);
    cen = 1'b0;
    a_roe_n = 1'b1;
    b_roe_n = 1'b1;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!rom_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 32'(rom_req), 32'd1);
  endtask

  task automatic serve(input int lat, input logic [7:0] d, input bit sim_a, input logic [24:0] sk);
    repeat (lat) @(negedge clk);
    rom_ok = 1'b1;
    rom_data = d;
    if (sim_a) begin
      cen = 1'b1;
      a_roe_n = 1'b0;
      {a_bank, a_addr} = sk;
    end
    @(negedge clk);
    rom_ok = 1'b0;
    rom_data = $urandom_range(0, 255);
    cen = 1'b0;
    a_roe_n = 1'b1;
  endtask

  task automatic check_idle();
    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("a_dout", 32'(a_dout), 32'(m_dout[0]));
    chk("b_dout", 32'(b_dout), 32'(m_dout[1]));
    chk("late", 32'(late), 32'(m_late));
  endtask

  // one cen strobe from either/both requesters, then service every miss it causes
  task automatic do_txn(input bit aa, input logic [24:0] ka, input bit ab, input logic [24:0] kb,
                        output int first_wait);
    bit ma, mb;
    bit ord[$];
    int n;
    logic [24:0] k;
    ma = aa && (!m_valid[0] || ka != m_last[0]);
    mb = ab && (!m_valid[1] || kb != m_last[1]);
    if (ma && mb) ord = m_lastg ? '{1'b0, 1'b1} : '{1'b1, 1'b0};
    else if (ma) ord = '{1'b0};
    else if (mb) ord = '{1'b1};
    foreach (ord[i]) begin
      k = ord[i] ? kb : ka;
      q.push_back('{sel: ord[i], addr: k, data: rb(k)});
    end
    pulse(aa, ka, ab, kb);
    first_wait = -1;
    foreach (ord[i]) begin
      k = ord[i] ? kb : ka;
      wait_req(n);
      if (i == 0) first_wait = n;
      serve($urandom_range(0, 3), rb(k), 1'b0, '0);
      m_dout[ord[i]] = rb(k);
      m_last[ord[i]] = k;
      m_valid[ord[i]] = 1'b1;
      m_lastg = ord[i];
    end
    check_idle();
  endtask

  initial begin
    int n, iss0;
    logic [24:0] k1, k2;
    rst_n = 1'b0;
    cen = 1'b0;
    a_roe_n = 1'b1;
    b_roe_n = 1'b1;
    a_addr = '0;
    a_bank = '0;
    b_addr = '0;
    rom_ok = 1'b0;
    rom_data = '0;
    clr_late = 2'b00;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_a_dout", 32'(a_dout), 32'd0);
    chk("rst_b_dout", 32'(b_dout), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rom_sel", 32'(rom_sel), 32'd0);
    chk("rst_rom_req", 32'(rom_req), 32'd0);
    chk("rst_late", 32'(late), 32'd0);
    rst_n = 1'b1;

    // single miss: bank 3 addr 0x10, byte 0x5A after minimum latency
    do_txn(1'b1, {5'd3, 20'h00010}, 1'b0, '0, n);
    chk("miss_latency", 32'(n), 32'd2);
    chk("miss_issues", 32'(issues), 32'd1);
    chk("miss_data", 32'(a_dout), 32'h5A);

    // hit: same key, no fetch
    iss0 = issues;
    do_txn(1'b1, {5'd3, 20'h00010}, 1'b0, '0, n);
    chk("hit_no_fetch", 32'(issues), 32'(iss0));
    chk("hit_data", 32'(a_dout), 32'h5A);

    // contention twice: order follows round robin
    do_txn(1'b1, {5'd1, 20'h00200}, 1'b1, 25'h0000300, n);
    do_txn(1'b1, {5'd1, 20'h00201}, 1'b1, 25'h0000301, n);

    // overwrite before issue while A occupies the port
    k1 = {5'd2, 20'h00400};
    q.push_back('{sel: 1'b0, addr: k1, data: rb(k1)});
    q.push_back('{sel: 1'b1, addr: 25'h0000101, data: rb(25'h0000101)});
    pulse(1'b1, k1, 1'b0, '0);
    wait_req(n);
    pulse(1'b0, '0, 1'b1, 25'h0000100);
    pulse(1'b0, '0, 1'b1, 25'h0000101);
    serve(1, rb(k1), 1'b0, '0);
    wait_req(n);
    serve(0, rb(25'h0000101), 1'b0, '0);
    m_dout[0] = rb(k1); m_last[0] = k1; m_valid[0] = 1'b1;
    m_dout[1] = rb(25'h0000101); m_last[1] = 25'h0000101; m_valid[1] = 1'b1;
    m_lastg = 1'b1;
    m_late = 2'b10;
    check_idle();
    @(negedge clk);
    clr_late = 2'b10;
    @(negedge clk);
    clr_late = 2'b00;
    m_late = 2'b00;
    chk("late_cleared", 32'(late), 32'd0);

    // new A key in the same cycle as rom_ok for A
    k1 = {5'd4, 20'h00500};
    k2 = {5'd4, 20'h00501};
    q.push_back('{sel: 1'b0, addr: k1, data: rb(k1)});
    q.push_back('{sel: 1'b0, addr: k2, data: rb(k2)});
    pulse(1'b1, k1, 1'b0, '0);
    wait_req(n);
    serve(0, rb(k1), 1'b1, k2);
    wait_req(n);
    serve(2, rb(k2), 1'b0, '0);
    m_dout[0] = rb(k2); m_last[0] = k2; m_lastg = 1'b0;
    m_late = 2'b01;
    check_idle();

    // reset during WAIT, stale rom_ok afterwards
    k1 = {5'd5, 20'h00600};
    q.push_back('{sel: 1'b0, addr: k1, data: rb(k1)});
    pulse(1'b1, k1, 1'b0, '0);
    wait_req(n);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    rom_ok = 1'b1;
    rom_data = 8'hFF;
    @(negedge clk);
    rom_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stale_rom_req", 32'(rom_req), 32'd0);
    end
    chk("rst2_a_dout", 32'(a_dout), 32'd0);
    chk("rst2_b_dout", 32'(b_dout), 32'd0);
    chk("rst2_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst2_rom_sel", 32'(rom_sel), 32'd0);
    chk("rst2_late", 32'(late), 32'd0);

    // randomized transactions from small key pools so hits and dual misses are common
    for (int t = 0; t < 40; t++) begin
      logic [24:0] ka, kb;
      ka = {5'($urandom_range(0, 2)), 20'($urandom_range(0, 3))};
      kb = 25'($urandom_range(0, 3));
      do_txn(1'($urandom_range(0, 1)), ka, 1'($urandom_range(0, 1)), kb, n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
